// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ex_muldiv_pkg - opcode map and shared types for ex_muldiv. Rev 1.0
// ------------------------------------------------------------------
package ex_muldiv_pkg;

  localparam logic RST_ENABLE = 1'b0;

  typedef enum logic [4:0] {
    EXE_ADD_OP    = 5'd0,
    EXE_SUB_OP    = 5'd1,
    EXE_SLL_OP    = 5'd2,
    EXE_SLT_OP    = 5'd3,
    EXE_SLTU_OP   = 5'd4,
    EXE_XOR_OP    = 5'd5,
    EXE_SRL_OP    = 5'd6,
    EXE_SRA_OP    = 5'd7,
    EXE_OR_OP     = 5'd8,
    EXE_AND_OP    = 5'd9,
    EXE_MUL_OP    = 5'd10,
    EXE_MULH_OP   = 5'd11,
    EXE_MULHSU_OP = 5'd12,
    EXE_MULHU_OP  = 5'd13,
    EXE_DIV_OP    = 5'd14,
    EXE_DIVU_OP   = 5'd15,
    EXE_REM_OP    = 5'd16,
    EXE_REMU_OP   = 5'd17,
    EXE_BAD_OP    = 5'd31
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Codes outside the defined range collapse onto EXE_BAD_OP.
  function automatic op_e decode_op(input logic [31:0] code);
    if (code <= 32'd17) return op_e'(code[4:0]);
    return EXE_BAD_OP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_iter.sv
`default_nettype none
// ------------------------------------------------------------------
// ex_muldiv_iter - radix-2 shift-add multiplier / restoring divider
// on operand magnitudes, one step per cycle. Rev 1.0
// ------------------------------------------------------------------
module ex_muldiv_iter
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              kill_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   op_a_i,
  input  logic [XLEN-1:0]   op_b_i,
  output logic              last_o,
  output logic [2*XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic              div_q;

  logic [XLEN:0]     w_add;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_step;

  // acc holds {hi, lo}: product halves for multiply, {remainder, quotient} for divide.
  always_comb begin
    w_add = {1'b0, acc_q[2*XLEN-1:XLEN]};
    if (acc_q[0]) w_add = w_add + {1'b0, b_q};
    w_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    w_diff  = w_shift - {1'b0, b_q};
    if (!div_q)
      w_step = {w_add, acc_q[XLEN-1:1]};
    else if (!w_diff[XLEN])
      w_step = {w_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      w_step = {w_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      cnt_q <= '0;
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (kill_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= CW'(XLEN);
      acc_q <= {{XLEN{1'b0}}, op_a_i};
      b_q   <= op_b_i;
      div_q <= is_div_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      acc_q <= w_step;
    end
  end

  assign last_o   = (cnt_q == CW'(1));
  assign result_o = w_step;

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ------------------------------------------------------------------
// ex_muldiv - RV32IM execute stage: single-cycle ALU plus iterative
// MUL/DIV/REM with pipeline stall request. Rev 1.0
// ------------------------------------------------------------------
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [XLEN-1:0]       reg1_i,
  input  logic [XLEN-1:0]       reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic                  stall_req_o
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

  op_e               w_op;
  logic [SHW-1:0]    w_sh;
  logic [XLEN-1:0]   w_alu, w_short, w_mag_a, w_mag_b, w_long_res;
  logic              w_long, w_is_div, w_dz, w_ovf, w_special;
  logic              w_sa, w_sb, w_start, w_last;
  logic [2*XLEN-1:0] w_acc, w_prod;

  state_e                state_q;
  op_e                   op_q;
  logic                  neg_q, neg_r_q, pwreg_q;
  logic [REG_ADDR_W-1:0] pwd_q;
  logic                  valid_q, wreg_q;
  logic [REG_ADDR_W-1:0] wd_q;
  logic [XLEN-1:0]       wdata_q;

  assign w_op     = decode_op(32'(aluop_i));
  assign w_sh     = reg2_i[SHW-1:0];
  assign w_long   = (w_op >= EXE_MUL_OP) && (w_op <= EXE_REMU_OP);
  assign w_is_div = (w_op >= EXE_DIV_OP) && (w_op <= EXE_REMU_OP);
  assign w_dz     = w_is_div && (reg2_i == '0);
  assign w_ovf    = ((w_op == EXE_DIV_OP) || (w_op == EXE_REM_OP)) &&
                    (reg1_i == C_MIN) && (reg2_i == '1);
  assign w_special = w_dz || w_ovf;

  always_comb begin
    w_alu = '0;
    case (w_op)
      EXE_ADD_OP:  w_alu = reg1_i + reg2_i;
      EXE_SUB_OP:  w_alu = reg1_i - reg2_i;
      EXE_SLL_OP:  w_alu = reg1_i << w_sh;
      EXE_SLT_OP:  w_alu = {{(XLEN-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      EXE_SLTU_OP: w_alu = {{(XLEN-1){1'b0}}, (reg1_i < reg2_i)};
      EXE_XOR_OP:  w_alu = reg1_i ^ reg2_i;
      EXE_SRL_OP:  w_alu = reg1_i >> w_sh;
      EXE_SRA_OP:  w_alu = $signed(reg1_i) >>> w_sh;
      EXE_OR_OP:   w_alu = reg1_i | reg2_i;
      EXE_AND_OP:  w_alu = reg1_i & reg2_i;
      default:     w_alu = '0;
    endcase
  end

  always_comb begin
    if (w_dz)
      w_short = ((w_op == EXE_DIV_OP) || (w_op == EXE_DIVU_OP)) ? '1 : reg1_i;
    else if (w_ovf)
      w_short = (w_op == EXE_DIV_OP) ? reg1_i : '0;
    else
      w_short = w_alu;
  end

  // The engine works on magnitudes; signedness is tracked here and reapplied at finish.
  assign w_sa = reg1_i[XLEN-1] && ((w_op == EXE_MUL_OP) || (w_op == EXE_MULH_OP) ||
                (w_op == EXE_MULHSU_OP) || (w_op == EXE_DIV_OP) || (w_op == EXE_REM_OP));
  assign w_sb = reg2_i[XLEN-1] && ((w_op == EXE_MUL_OP) || (w_op == EXE_MULH_OP) ||
                (w_op == EXE_DIV_OP) || (w_op == EXE_REM_OP));
  assign w_mag_a = w_sa ? -reg1_i : reg1_i;
  assign w_mag_b = w_sb ? -reg2_i : reg2_i;

  assign w_start = (state_q == ST_IDLE) && valid_i && !flush_i && w_long && !w_special;
  assign stall_req_o = (rst != RST_ENABLE) && !flush_i &&
                       (w_start || ((state_q == ST_BUSY) && !w_last));

  ex_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (w_start),
    .kill_i   (flush_i),
    .is_div_i (w_is_div),
    .op_a_i   (w_mag_a),
    .op_b_i   (w_mag_b),
    .last_o   (w_last),
    .result_o (w_acc)
  );

  assign w_prod = neg_q ? -w_acc : w_acc;

  always_comb begin
    case (op_q)
      EXE_MUL_OP:                            w_long_res = w_prod[XLEN-1:0];
      EXE_MULH_OP, EXE_MULHSU_OP,
      EXE_MULHU_OP:                          w_long_res = w_prod[2*XLEN-1:XLEN];
      EXE_DIV_OP, EXE_DIVU_OP:               w_long_res = neg_q ? -w_acc[XLEN-1:0] : w_acc[XLEN-1:0];
      EXE_REM_OP, EXE_REMU_OP:               w_long_res = neg_r_q ? -w_acc[2*XLEN-1:XLEN]
                                                                  : w_acc[2*XLEN-1:XLEN];
      default:                               w_long_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= ST_IDLE;
      op_q    <= EXE_ADD_OP;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      pwd_q   <= '0;
      pwreg_q <= 1'b0;
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
      wd_q    <= '0;
      wdata_q <= '0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_q <= 1'b0;
          wreg_q  <= 1'b0;
          if (w_start) begin
            state_q <= ST_BUSY;
            op_q    <= w_op;
            neg_q   <= w_sa ^ w_sb;
            neg_r_q <= w_sa;
            pwd_q   <= wd_i;
            pwreg_q <= wreg_i;
          end else if (valid_i) begin
            valid_q <= 1'b1;
            wdata_q <= w_short;
            wd_q    <= wd_i;
            wreg_q  <= wreg_i && (wd_i != '0) && (w_op != EXE_BAD_OP);
          end
        end
        ST_BUSY: begin
          valid_q <= 1'b0;
          wreg_q  <= 1'b0;
          if (w_last) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b1;
            wdata_q <= w_long_res;
            wd_q    <= pwd_q;
            wreg_q  <= pwreg_q && (pwd_q != '0);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign valid_o = valid_q;
  assign wd_o    = wd_q;
  assign wreg_o  = wreg_q;
  assign wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ex_muldiv - directed vectors against an arithmetic reference
// model for the RV32IM execute stage. Rev 1.0
// ------------------------------------------------------------------
module tb_ex_muldiv;

  localparam int OP_ADD = 0,  OP_SUB = 1,  OP_SLL = 2,  OP_SLT = 3,  OP_SLTU = 4;
  localparam int OP_XOR = 5,  OP_SRL = 6,  OP_SRA = 7,  OP_OR = 8,   OP_AND = 9;
  localparam int OP_MUL = 10, OP_MULH = 11, OP_MULHSU = 12, OP_MULHU = 13;
  localparam int OP_DIV = 14, OP_DIVU = 15, OP_REM = 16, OP_REMU = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic [7:0]  aluop_i = '0;
  logic [31:0] reg1_i = '0;
  logic [31:0] reg2_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_o, wreg_o, stall_req_o;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  wd;
    logic        wr;
  } exp_t;
  exp_t exp_q[$];

  ex_muldiv #(.XLEN(32), .REG_ADDR_W(5), .ALUOP_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .aluop_i     (aluop_i),
    .reg1_i      (reg1_i),
    .reg2_i      (reg2_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stall_req_o (stall_req_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_SLL:    return a << b[4:0];
      OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
      OP_XOR:    return a ^ b;
      OP_SRL:    return a >> b[4:0];
      OP_SRA:    begin p = 64'(sa >>> b[4:0]); return p[31:0]; end
      OP_OR:     return a | b;
      OP_AND:    return a & b;
      OP_MUL:    begin p = ua * ub; return p[31:0]; end
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = 64'(sa / sb);
        return p[31:0];
      end
      OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb);
        return p[31:0];
      end
      OP_REMU:   return (b == 32'd0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  // Cycle in which the result appears, counted from the presenting cycle.
  function automatic int lat_of(input int op, input logic [31:0] a, input logic [31:0] b);
    logic dz, ovf;
    dz  = (op >= OP_DIV && op <= OP_REMU) && (b == 32'd0);
    ovf = (op == OP_DIV || op == OP_REM) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (op >= OP_MUL && op <= OP_REMU && !dz && !ovf) return 33;
    return 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic drive(input logic v, input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wr);
    valid_i = v;
    aluop_i = op[7:0];
    reg1_i  = a;
    reg2_i  = b;
    wd_i    = wd;
    wreg_i  = wr;
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd,
                       input logic wr, input logic [31:0] lit, input string nm);
    int lat, nst, bad, seen;
    logic [31:0] got;
    exp_t e;
    lat  = lat_of(op, a, b);
    e.d  = model(op, a, b);
    e.wd = wd;
    e.wr = wr && (wd != 5'd0) && (op >= 0) && (op <= 17);
    exp_q.push_back(e);
    @(posedge clk); #1;
    drive(1'b1, op, a, b, wd, wr);
    seen = -1; nst = 0; bad = 0; got = '0;
    for (int c = 0; c < 48 && seen < 0; c++) begin
      @(negedge clk);
      if (stall_req_o) begin
        nst++;
        if (c >= lat - 1) bad++;
      end
      if (valid_o) begin
        seen = c;
        got  = wdata_o;
      end else begin
        @(posedge clk); #1;
        // Scramble the inputs while busy; they must be ignored.
        if (c + 1 < lat - 1)
          drive(1'b1, int'($urandom_range(0, 17)), $urandom, $urandom,
                5'($urandom_range(1, 31)), 1'b1);
        else
          idle();
      end
    end
    chk({nm, " latency"}, 32'(seen), 32'(lat));
    chk({nm, " stall cycles"}, 32'(nst), 32'(lat - 1));
    chk({nm, " late stall"}, 32'(bad), 32'd0);
    chk({nm, " wdata"}, got, lit);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray valid_o: got 1 with wdata %h, required 0", wdata_o);
        end else begin
          e = exp_q.pop_front();
          chk("model wdata", wdata_o, e.d);
          chk("model wd", 32'(wd_o), 32'(e.wd));
          chk("model wreg", 32'(wreg_o), 32'(e.wr));
        end
      end else begin
        chk("wreg without valid", 32'(wreg_o), 32'd0);
      end
    end
  end

  initial begin
    int st;
    rst = 1'b0;
    drive(1'b1, OP_MUL, 32'h1234, 32'h5678, 5'd9, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset valid_o", 32'(valid_o), 32'd0);
    chk("reset wreg_o", 32'(wreg_o), 32'd0);
    chk("reset wd_o", 32'(wd_o), 32'd0);
    chk("reset wdata_o", wdata_o, 32'd0);
    chk("reset stall", 32'(stall_req_o), 32'd0);
    @(posedge clk); #1;
    idle();
    rst = 1'b1;

    issue(OP_ADD,  32'h7FFF_FFFF, 32'h1,         5'd1, 1'b1, 32'h8000_0000, "ADD ovf");
    issue(OP_SRA,  32'h8000_0000, 32'h24,        5'd2, 1'b1, 32'hF800_0000, "SRA");
    issue(OP_SLTU, 32'h1,         32'hFFFF_FFFF, 5'd3, 1'b1, 32'h1,         "SLTU");
    issue(OP_SLT,  32'h1,         32'hFFFF_FFFF, 5'd3, 1'b1, 32'h0,         "SLT");
    issue(OP_SUB,  32'h3,         32'h5,         5'd4, 1'b1, 32'hFFFF_FFFE, "SUB");
    issue(OP_SLL,  32'h1,         32'h21,        5'd4, 1'b1, 32'h2,         "SLL");
    issue(OP_SRL,  32'h8000_0000, 32'h4,         5'd4, 1'b1, 32'h0800_0000, "SRL");
    issue(OP_XOR,  32'hF0F0,      32'hFF00,      5'd6, 1'b1, 32'h0FF0,      "XOR");
    issue(OP_OR,   32'hF0F0,      32'hFF00,      5'd6, 1'b1, 32'hFFF0,      "OR");
    issue(OP_AND,  32'hF0F0,      32'hFF00,      5'd6, 1'b1, 32'hF000,      "AND");
    @(posedge clk);
    @(negedge clk);
    chk("idle valid_o", 32'(valid_o), 32'd0);
    chk("idle wdata hold", wdata_o, 32'hF000);
    issue(200, 32'h5, 32'h6, 5'd7, 1'b1, 32'h0, "unknown op");
    chk("unknown op wreg", 32'(wreg_o), 32'd0);

    issue(OP_MUL,    32'hFFFF_FFFF, 32'h7,         5'd8,  1'b1, 32'hFFFF_FFF9, "MUL");
    issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  1'b1, 32'hFFFF_FFFE, "MULHU");
    issue(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  1'b1, 32'h0,         "MULH");
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'h2,         5'd8,  1'b1, 32'hFFFF_FFFF, "MULHSU");
    issue(OP_DIV,    32'hFFFF_FFF9, 32'h2,         5'd10, 1'b1, 32'hFFFF_FFFD, "DIV neg");
    issue(OP_REM,    32'hFFFF_FFF9, 32'h2,         5'd10, 1'b1, 32'hFFFF_FFFF, "REM neg");
    issue(OP_DIVU,   32'h7,         32'h2,         5'd10, 1'b1, 32'h3,         "DIVU");
    issue(OP_REMU,   32'h7,         32'h2,         5'd10, 1'b1, 32'h1,         "REMU");
    issue(OP_DIV,    32'h5,         32'h0,         5'd11, 1'b1, 32'hFFFF_FFFF, "DIV by 0");
    issue(OP_REMU,   32'h5,         32'h0,         5'd11, 1'b1, 32'h5,         "REMU by 0");
    issue(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'h8000_0000, "DIV ovf");
    issue(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'h0,         "REM ovf");

    issue(OP_ADD, 32'h1, 32'h1, 5'd0, 1'b1, 32'h2, "ADD x0");
    chk("x0 valid", 32'(valid_o), 32'd1);
    chk("x0 wreg", 32'(wreg_o), 32'd0);
    issue(OP_ADD, 32'h1, 32'h2, 5'd5, 1'b1, 32'h3, "ADD x5");
    chk("x5 wd", 32'(wd_o), 32'd5);
    chk("x5 wreg", 32'(wreg_o), 32'd1);

    // Flush in BUSY cycle 10 of a DIV, then an ADD right behind it.
    @(posedge clk); #1;
    drive(1'b1, OP_DIV, 32'd100, 32'd7, 5'd4, 1'b1);
    st = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      idle();
      if (c == 10) flush_i = 1'b1;
      @(negedge clk);
      if (c < 10 && stall_req_o) st++;
    end
    chk("busy stall before flush", 32'(st), 32'd9);
    chk("flush stall", 32'(stall_req_o), 32'd0);
    chk("flush valid", 32'(valid_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    exp_q.push_back('{d: 32'd5, wd: 5'd3, wr: 1'b1});
    drive(1'b1, OP_ADD, 32'd2, 32'd3, 5'd3, 1'b1);
    @(negedge clk);
    chk("post-flush cycle 11 valid", 32'(valid_o), 32'd0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("post-flush ADD valid", 32'(valid_o), 32'd1);
    chk("post-flush ADD wdata", wdata_o, 32'd5);
    repeat (40) @(posedge clk);

    // Asynchronous reset in the middle of a DIV.
    @(posedge clk); #1;
    drive(1'b1, OP_DIV, 32'd100, 32'd7, 5'd4, 1'b1);
    repeat (5) begin
      @(posedge clk); #1;
      idle();
    end
    rst = 1'b0;
    #1;
    chk("async rst valid", 32'(valid_o), 32'd0);
    chk("async rst wdata", wdata_o, 32'd0);
    chk("async rst wd", 32'(wd_o), 32'd0);
    chk("async rst wreg", 32'(wreg_o), 32'd0);
    chk("async rst stall", 32'(stall_req_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    issue(OP_ADD, 32'd10, 32'd20, 5'd12, 1'b1, 32'd30, "ADD after rst");
    issue(OP_MUL, 32'd6,  32'd7,  5'd12, 1'b1, 32'd42, "MUL after rst");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending results: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
